alu_ctr: RTL and testbench

ALU control decoder for the single-cycle/multi-cycle MIPS datapath. It sits between the main control unit and the ALU. It translates the 2-bit `aluOp` from main control and the 6-bit R-type `funct` field into the 4-bit ALU operation select. It also provides a registered copy of the select and registered illegal-funct monitoring for debug.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_ctr_if.sv | 27 ++
 rtl/alu_ctr_decode.sv | 42 ++++
 rtl/alu_ctr.sv | 64 ++++++
 tb/tb_alu_ctr.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select, aluOp class and R-type funct-nibble constants.
// Used by the ALU control decoder and by the ALU itself.
package alu_pkg;

  localparam int unsigned ALU_SEL_W = 4;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned NIB_W     = 4;

  // ALU operation select encodings
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 4'b1100;

  // aluOp classes from main control (OP_RTYPE is any value with bit 1 set)
  localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
  localparam logic [OP_W-1:0] OP_RTYPE = 2'b10;

  // R-type funct[3:0] nibbles
  localparam logic [NIB_W-1:0] FN_ADD  = 4'b0000;
  localparam logic [NIB_W-1:0] FN_ADDU = 4'b0001;
  localparam logic [NIB_W-1:0] FN_SUB  = 4'b0010;
  localparam logic [NIB_W-1:0] FN_SUBU = 4'b0011;
  localparam logic [NIB_W-1:0] FN_AND  = 4'b0100;
  localparam logic [NIB_W-1:0] FN_OR   = 4'b0101;
  localparam logic [NIB_W-1:0] FN_XOR  = 4'b0110;
  localparam logic [NIB_W-1:0] FN_NOR  = 4'b0111;
  localparam logic [NIB_W-1:0] FN_SLT  = 4'b1010;
  localparam logic [NIB_W-1:0] FN_SLTU = 4'b1011;

endpackage

// File: rtl/alu_ctr_if.sv
// alu_ctr_if: control-side bundle of the ALU control decoder.
//   master: drives aluOp, funct, clr; observes all decoder outputs.
//   slave : the decoder; drives aluCtr, illegal, aluCtr_q, illegal_sticky, illegal_cnt.
interface alu_ctr_if
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic [OP_W-1:0]      aluOp;
  logic [FUNCT_W-1:0]   funct;
  logic                 clr;
  logic [ALU_SEL_W-1:0] aluCtr;
  logic                 illegal;
  logic [ALU_SEL_W-1:0] aluCtr_q;
  logic                 illegal_sticky;
  logic [CNT_W-1:0]     illegal_cnt;

  modport master (
    output aluOp, funct, clr,
    input  aluCtr, illegal, aluCtr_q, illegal_sticky, illegal_cnt
  );

  modport slave (
    input  aluOp, funct, clr,
    output aluCtr, illegal, aluCtr_q, illegal_sticky, illegal_cnt
  );
endinterface

// File: rtl/alu_ctr_decode.sv
// alu_ctr_decode: pure combinational ALU select decoder.
//   aluOp, funct -> aluCtr (ALU select), illegal (undefined R-type funct).
module alu_ctr_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]      aluOp,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALU_SEL_W-1:0] aluCtr,
  output logic                 illegal
);

  // funct[5:4] never participate in the decode
  logic unused_funct_hi;
  assign unused_funct_hi = ^funct[FUNCT_W-1:NIB_W];

  // aluOp[1] selects R-type regardless of aluOp[0]
  always_comb begin
    aluCtr  = ALU_ADD;
    illegal = 1'b0;
    if (aluOp[1]) begin
      case (funct[NIB_W-1:0])
        FN_ADD, FN_ADDU: aluCtr = ALU_ADD;
        FN_SUB, FN_SUBU: aluCtr = ALU_SUB;
        FN_AND:          aluCtr = ALU_AND;
        FN_OR:           aluCtr = ALU_OR;
        FN_XOR:          aluCtr = ALU_XOR;
        FN_NOR:          aluCtr = ALU_NOR;
        FN_SLT:          aluCtr = ALU_SLT;
        FN_SLTU:         aluCtr = ALU_SLTU;
        default: begin
          aluCtr  = ALU_ADD;
          illegal = 1'b1;
        end
      endcase
    end else if (aluOp == OP_SUB) begin
      aluCtr = ALU_SUB;
    end else begin
      aluCtr = ALU_ADD;
    end
  end

endmodule

// File: rtl/alu_ctr.sv
// alu_ctr: ALU control decoder with registered select and illegal-funct monitor.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_ctr_if slave (aluOp/funct/clr in; aluCtr/illegal comb out;
//                aluCtr_q/illegal_sticky/illegal_cnt registered out)
module alu_ctr
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_ctr_if.slave    bus
);

  logic [ALU_SEL_W-1:0] alu_ctr_c;
  logic                 illegal_c;

  logic [ALU_SEL_W-1:0] sel_d,    sel_q;
  logic                 sticky_d, sticky_q;
  logic [CNT_W-1:0]     cnt_d,    cnt_q;

  alu_ctr_decode u_decode (
    .aluOp   (bus.aluOp),
    .funct   (bus.funct),
    .aluCtr  (alu_ctr_c),
    .illegal (illegal_c)
  );

  // Next-state: clr beats a simultaneous illegal; counter saturates at all-ones
  always_comb begin
    sel_d    = alu_ctr_c;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (bus.clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (illegal_c) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= ALU_ADD;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.aluCtr         = alu_ctr_c;
  assign bus.illegal        = illegal_c;
  assign bus.aluCtr_q       = sel_q;
  assign bus.illegal_sticky = sticky_q;
  assign bus.illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_ctr.sv
// tb_alu_ctr: directed-vector bench for alu_ctr with hand-computed expectations.
module tb_alu_ctr;

  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_ctr_if #(.CNT_W(CNT_W)) bus ();

  alu_ctr #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {aluOp[1:0], funct[5:0], aluCtr[3:0], illegal}
  localparam int unsigned NV = 24;
  logic [12:0] vecs [NV] = '{
    {2'b00, 6'b000000, 4'b0010, 1'b0},
    {2'b01, 6'b000000, 4'b0110, 1'b0},
    {2'b10, 6'b000000, 4'b0010, 1'b0},
    {2'b10, 6'b000010, 4'b0110, 1'b0},
    {2'b10, 6'b000100, 4'b0000, 1'b0},
    {2'b10, 6'b000101, 4'b0001, 1'b0},
    {2'b10, 6'b001010, 4'b0111, 1'b0},
    {2'b10, 6'b100000, 4'b0010, 1'b0},
    {2'b10, 6'b100010, 4'b0110, 1'b0},
    {2'b10, 6'b100100, 4'b0000, 1'b0},
    {2'b10, 6'b100101, 4'b0001, 1'b0},
    {2'b10, 6'b101010, 4'b0111, 1'b0},
    {2'b11, 6'b000010, 4'b0110, 1'b0},
    {2'b11, 6'b000101, 4'b0001, 1'b0},
    {2'b11, 6'b001011, 4'b1000, 1'b0},
    {2'b00, 6'b001000, 4'b0010, 1'b0},
    {2'b01, 6'b111111, 4'b0110, 1'b0},
    {2'b00, 6'b101010, 4'b0010, 1'b0},
    {2'b10, 6'b000110, 4'b0011, 1'b0},
    {2'b10, 6'b000111, 4'b1100, 1'b0},
    {2'b10, 6'b001011, 4'b1000, 1'b0},
    {2'b10, 6'b000001, 4'b0010, 1'b0},
    {2'b10, 6'b000011, 4'b0110, 1'b0},
    {2'b10, 6'b110111, 4'b1100, 1'b0}
  };

  // Undefined R-type nibbles (with varied high bits and aluOp[0])
  localparam int unsigned NI = 6;
  logic [7:0] ill_vecs [NI] = '{
    {2'b10, 6'b001000}, {2'b10, 6'b001001}, {2'b11, 6'b001100},
    {2'b10, 6'b111101}, {2'b11, 6'b011110}, {2'b10, 6'b101111}
  };

  initial begin
    logic [12:0] v;
    n_tests = 0;
    n_fail  = 0;

    // Reset with an illegal funct applied: registers must hold reset values
    rst_n      = 1'b0;
    bus.aluOp  = 2'b10;
    bus.funct  = 6'b001000;
    bus.clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aluCtr_q", 16'(bus.aluCtr_q), 16'h2);
    chk("rst_sticky", 16'(bus.illegal_sticky), 16'h0);
    chk("rst_cnt", 16'(bus.illegal_cnt), 16'h0);
    chk("rst_comb_ctr", 16'(bus.aluCtr), 16'h2);
    chk("rst_comb_ill", 16'(bus.illegal), 16'h1);

    // Release between edges with a legal funct
    bus.funct = 6'b000100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Legal sweep: comb result immediately, registered copy one edge later
    for (int i = 0; i < int'(NV); i++) begin
      v         = vecs[i];
      bus.aluOp = v[12:11];
      bus.funct = v[10:5];
      #1;
      chk($sformatf("ctr_v%0d", i), 16'(bus.aluCtr), 16'(v[4:1]));
      chk($sformatf("ill_v%0d", i), 16'(bus.illegal), 16'(v[0]));
      @(posedge clk);
      #1;
      chk($sformatf("ctrq_v%0d", i), 16'(bus.aluCtr_q), 16'(v[4:1]));
    end
    chk("sweep_sticky", 16'(bus.illegal_sticky), 16'h0);
    chk("sweep_cnt", 16'(bus.illegal_cnt), 16'h0);

    // Illegal nibbles, comb only
    for (int i = 0; i < int'(NI); i++) begin
      bus.aluOp = ill_vecs[i][7:6];
      bus.funct = ill_vecs[i][5:0];
      #1;
      chk($sformatf("ctr_ill%0d", i), 16'(bus.aluCtr), 16'h2);
      chk($sformatf("ill_ill%0d", i), 16'(bus.illegal), 16'h1);
    end

    // One illegal cycle, then legal cycles hold the monitor
    bus.aluOp = 2'b10;
    bus.funct = 6'b001000;
    @(posedge clk);
    #1;
    chk("one_sticky", 16'(bus.illegal_sticky), 16'h1);
    chk("one_cnt", 16'(bus.illegal_cnt), 16'h1);
    chk("one_ctrq", 16'(bus.aluCtr_q), 16'h2);
    bus.funct = 6'b000111;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_sticky", 16'(bus.illegal_sticky), 16'h1);
    chk("hold_cnt", 16'(bus.illegal_cnt), 16'h1);
    chk("hold_ctrq", 16'(bus.aluCtr_q), 16'hC);

    // Hold illegal: 1 + 9 = 10, then to 300 total -> saturates at 255
    bus.funct = 6'b001111;
    repeat (9) @(posedge clk);
    #1;
    chk("cnt_10", 16'(bus.illegal_cnt), 16'd10);
    repeat (244) @(posedge clk);
    #1;
    chk("cnt_254", 16'(bus.illegal_cnt), 16'd254);
    @(posedge clk);
    #1;
    chk("cnt_255", 16'(bus.illegal_cnt), 16'd255);
    repeat (45) @(posedge clk);
    #1;
    chk("cnt_sat", 16'(bus.illegal_cnt), 16'd255);
    chk("sat_sticky", 16'(bus.illegal_sticky), 16'h1);

    // clr wins over a simultaneous illegal
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_sticky", 16'(bus.illegal_sticky), 16'h0);
    chk("clr_cnt", 16'(bus.illegal_cnt), 16'h0);
    bus.clr = 1'b0;

    // Build a nonzero count, then reset asynchronously mid-cycle
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_cnt", 16'(bus.illegal_cnt), 16'd3);
    bus.funct = 6'b000101;
    @(posedge clk);
    #1;
    chk("pre_rst_ctrq", 16'(bus.aluCtr_q), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ctrq", 16'(bus.aluCtr_q), 16'h2);
    chk("async_sticky", 16'(bus.illegal_sticky), 16'h0);
    chk("async_cnt", 16'(bus.illegal_cnt), 16'h0);
    chk("async_comb", 16'(bus.aluCtr), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ctrq", 16'(bus.aluCtr_q), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
